// File: rtl/cmd_master.sv
`default_nettype none
// =============================================================================
// Module      : cmd_master
// Description : Frames RF read/write and ALU commands into a UART byte stream
//               and collects the 0/1/2-byte reply. Define CMD_MASTER_TIMEOUT_EN
//               to bound the reply wait by TIMEOUT_CYCLES.
// Revision    : 1.0 - initial release
// =============================================================================
module cmd_master #(
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
   input  logic        i_clk,
   input  logic        i_arst,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic [1:0]  i_req_op,
   input  logic [3:0]  i_req_addr,
   input  logic [7:0]  i_req_data,
   input  logic [7:0]  i_req_opa,
   input  logic [7:0]  i_req_opb,
   input  logic [3:0]  i_req_fun,
   output logic        o_tx_valid,
   output logic [7:0]  o_tx_data,
   input  logic        i_tx_ready,
   input  logic        i_rx_valid,
   input  logic [7:0]  i_rx_data,
   output logic        o_rsp_valid,
   output logic [15:0] o_rsp_data,
   output logic        o_rsp_timeout,
   output logic        o_busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   localparam logic [1:0] c_OP_WR  = 2'b00;
   localparam logic [1:0] c_OP_RD  = 2'b01;
   localparam logic [1:0] c_OP_ALU = 2'b10;

   state_t      r_state, w_state_next;
   logic [1:0]  r_op, r_tx_idx, w_last_idx;
   logic [3:0]  r_addr, r_fun;
   logic [7:0]  r_data, r_opa, r_opb, r_rx_b0, w_tx_byte;
   logic        r_rx_cnt, r_rsp_valid, r_rsp_timeout;
   logic [15:0] r_rsp_data;
   logic        w_tx_hs, w_tx_last, w_rx_final, w_timeout;

   assign w_tx_hs    = (r_state == S_SEND) && i_tx_ready;
   assign w_tx_last  = (r_tx_idx == w_last_idx);
   // Reads complete on their only byte, ALU replies on the second.
   assign w_rx_final = (r_state == S_WAIT) && i_rx_valid && ((r_op == c_OP_RD) || r_rx_cnt);

   always_comb begin
      w_last_idx = 2'd1;
      w_tx_byte  = 8'h00;
      case (r_op)
         2'b00: begin
            w_last_idx = 2'd2;
            case (r_tx_idx)
               2'd0:    w_tx_byte = 8'hAA;
               2'd1:    w_tx_byte = {4'h0, r_addr};
               default: w_tx_byte = r_data;
            endcase
         end
         2'b01:   w_tx_byte = (r_tx_idx == 2'd0) ? 8'hBB : {4'h0, r_addr};
         2'b10: begin
            w_last_idx = 2'd3;
            case (r_tx_idx)
               2'd0:    w_tx_byte = 8'hCC;
               2'd1:    w_tx_byte = r_opa;
               2'd2:    w_tx_byte = r_opb;
               default: w_tx_byte = {4'h0, r_fun};
            endcase
         end
         default: w_tx_byte = (r_tx_idx == 2'd0) ? 8'hDD : {4'h0, r_fun};
      endcase
   end

`ifdef CMD_MASTER_TIMEOUT_EN
   // Counts cycles since the frame finished or the last reply byte arrived.
   logic [15:0] r_timer;

   assign w_timeout = (r_state == S_WAIT) && !i_rx_valid &&
                      (({1'b0, r_timer} + 17'd1) >= {1'b0, TIMEOUT_CYCLES});

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         r_timer <= 16'd0;
      end else if (w_tx_hs && w_tx_last) begin
         r_timer <= 16'd1;
      end else if (r_state == S_WAIT) begin
         r_timer <= i_rx_valid ? 16'd1 : r_timer + 16'd1;
      end
   end
`else
   logic w_unused_timeout;
   assign w_unused_timeout = ^TIMEOUT_CYCLES;
   assign w_timeout        = 1'b0;
`endif

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      o_req_ready  = 1'b0;
      o_tx_valid   = 1'b0;
      o_tx_data    = 8'h00;
      o_busy       = 1'b1;
      case (r_state)
         S_IDLE: begin
            o_busy      = 1'b0;
            o_req_ready = !i_arst;
            if (i_req_valid && !i_arst) w_state_next = S_SEND;
         end
         S_SEND: begin
            o_tx_valid = 1'b1;
            o_tx_data  = w_tx_byte;
            if (w_tx_hs && w_tx_last) w_state_next = (r_op == c_OP_WR) ? S_IDLE : S_WAIT;
         end
         S_WAIT: begin
            if (w_rx_final || w_timeout) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         r_op          <= 2'd0;
         r_addr        <= 4'd0;
         r_data        <= 8'd0;
         r_opa         <= 8'd0;
         r_opb         <= 8'd0;
         r_fun         <= 4'd0;
         r_tx_idx      <= 2'd0;
         r_rx_cnt      <= 1'b0;
         r_rx_b0       <= 8'd0;
         r_rsp_valid   <= 1'b0;
         r_rsp_data    <= 16'd0;
         r_rsp_timeout <= 1'b0;
      end else begin
         r_rsp_valid <= 1'b0;
         if (r_state == S_IDLE && i_req_valid) begin
            r_op     <= i_req_op;
            r_addr   <= i_req_addr;
            r_data   <= i_req_data;
            r_opa    <= i_req_opa;
            r_opb    <= i_req_opb;
            r_fun    <= i_req_fun;
            r_tx_idx <= 2'd0;
         end
         if (w_tx_hs) begin
            r_tx_idx <= r_tx_idx + 2'd1;
            if (w_tx_last) begin
               r_rx_cnt <= 1'b0;
               r_rx_b0  <= 8'h00;
               if (r_op == c_OP_WR) begin
                  r_rsp_valid   <= 1'b1;
                  r_rsp_data    <= 16'h0000;
                  r_rsp_timeout <= 1'b0;
               end
            end
         end
         if (w_rx_final) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_timeout <= 1'b0;
            r_rsp_data    <= (r_op == c_OP_RD) ? {8'h00, i_rx_data} : {i_rx_data, r_rx_b0};
         end else if (r_state == S_WAIT && i_rx_valid) begin
            r_rx_b0  <= i_rx_data;
            r_rx_cnt <= 1'b1;
         end else if (w_timeout) begin
            // Only the low byte can be present here; missing bytes read as zero.
            r_rsp_valid   <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_rsp_data    <= {8'h00, r_rx_b0};
         end
      end
   end

   assign o_rsp_valid   = r_rsp_valid;
   assign o_rsp_data    = r_rsp_data;
   assign o_rsp_timeout = r_rsp_timeout;

endmodule
`default_nettype wire

// File: doc/cmd_master.md
CMD_MASTER -- requirements
Module: cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd50000, response-wait limit in i_clk cycles (16-bit, nonzero).
REQ-002 SHALL have i_clk  input  1  sole clock, all logic rising-edge.
REQ-003 SHALL have i_arst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have i_req_valid  input  1  command request present.
REQ-005 SHALL have o_req_ready  output  1  request accepted when high with i_req_valid.
REQ-006 SHALL have i_req_op  input  2  00 RF write, 01 RF read, 10 ALU with operands, 11 ALU no operands.
REQ-007 SHALL have i_req_addr  input  4  RF address.
REQ-008 SHALL have i_req_data  input  8  RF write data.
REQ-009 SHALL have i_req_opa / i_req_opb  input  8 each  ALU operands A/B.
REQ-010 SHALL have i_req_fun  input  4  ALU function.
REQ-011 SHALL have o_tx_valid, o_tx_data[7:0] output and i_tx_ready input, the byte stream toward the UART transmitter.
REQ-012 SHALL have i_rx_valid  input  1 and i_rx_data  input  8, the response bytes from the UART receiver, one-cycle strobe per byte.
REQ-013 SHALL have o_rsp_valid  output  1  one-cycle completion pulse; o_rsp_data  output  16  result; o_rsp_timeout  output  1  qualifies o_rsp_valid.
REQ-014 SHALL have o_busy  output  1  high whenever not IDLE.

Function
REQ-015 SHALL implement FSM IDLE -> SEND -> WAIT_RSP -> IDLE; RF write goes SEND -> IDLE.
REQ-016 o_req_ready SHALL equal (state==IDLE) and be 0 while i_arst high; all request fields captured on the valid&ready cycle N.
REQ-017 Frames SHALL be: write AA, {4'h0,addr}, data; read BB, {4'h0,addr}; ALU-op CC, A, B, {4'h0,fun}; ALU-nop DD, {4'h0,fun}.
REQ-018 First frame byte SHALL appear with o_tx_valid at cycle N+1; byte advances only on o_tx_valid&i_tx_ready; o_tx_data held stable while stalled; no bubbles between bytes.
REQ-019 Expected response length: write 0, read 1 byte, ALU 2 bytes LSB first.
REQ-020 Write: o_rsp_valid SHALL pulse the cycle after the last byte handshake with o_rsp_data=0, then IDLE.
REQ-021 Read: o_rsp_data SHALL be {8'h00, byte}; ALU: {byte1, byte0}; o_rsp_valid pulses the cycle after the final expected byte arrives.
REQ-022 i_rx_valid outside WAIT_RSP, including the final tx handshake cycle, SHALL be ignored.
REQ-023 o_rsp_data SHALL hold its value until the next o_rsp_valid.

Reset
REQ-024 On i_arst: state IDLE, o_tx_valid 0, o_tx_data 0, o_rsp_valid 0, o_rsp_data 0, o_rsp_timeout 0, o_busy 0, counters 0.
REQ-025 Reset mid-frame or mid-wait SHALL abort with no o_rsp_valid pulse; first request accepted the first cycle i_arst is low.

Configuration
REQ-026 Macro CMD_MASTER_TIMEOUT_EN defined: a 16-bit counter runs in WAIT_RSP, clears on each received byte, and on reaching TIMEOUT_CYCLES pulses o_rsp_valid with o_rsp_timeout=1, o_rsp_data = bytes received so far (missing bytes 0), returns to IDLE.
REQ-027 Macro undefined: no counter, WAIT_RSP waits indefinitely, o_rsp_timeout tied 0.

Verification
REQ-028 Write op=00 addr=5 data=3C, i_tx_ready=1 -> tx AA,05,3C on consecutive cycles, rsp pulse data 0000.
REQ-029 Read addr=2, reply byte 81 -> tx BB,02; rsp_data 0081, timeout 0, pulse one cycle after byte.
REQ-030 ALU-op A=10 B=20 fun=0, i_tx_ready toggling 1/0 -> tx CC,10,20,00 with stable data during stalls; replies 30,00 -> rsp_data 0030.
REQ-031 With CMD_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=100, ALU-nop fun=3, one reply byte 07 then silence -> rsp pulse 100 cycles after byte, timeout 1, data 0007.
REQ-032 i_arst pulsed during third byte of CC frame -> o_tx_valid 0, o_busy 0, no rsp pulse, stray rx byte afterward ignored, next request accepted normally.
